// File: rtl/audio_pkg.sv
// Shared audio constants and the serializer state encoding.
package audio_pkg;

  localparam int AUDIO_DATA_W  = 18;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_BCLK_DIV  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } i2s_state_e;

endpackage

// File: rtl/i2s_bit_timer.sv
// BCLK divider and frame bit counter for the I2S serializer.
// Strobes describe the values the counters take on the next clk edge,
// so the parent can register its outputs in step with the counters.
module i2s_bit_timer import audio_pkg::*; #(
  parameter int BCLK_DIV  = I2S_BCLK_DIV,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int BIT_W     = $clog2(2*SLOT_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [BIT_W-1:0] bit_nxt,
  output logic             fs_nxt,
  output logic             fall_nxt,
  output logic             bclk_nxt,
  output logic             last_cyc
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(2*SLOT_BITS - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

  // Next counter values: clear wins, bit_cnt steps only when div_cnt wraps.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (adv) begin
      if (div_cnt_q == DIV_MAX) begin
        div_cnt_d = '0;
        bit_cnt_d = (bit_cnt_q == BIT_MAX) ? '0 : bit_cnt_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_nxt  = bit_cnt_d;
  assign fall_nxt = (div_cnt_d == '0);
  assign fs_nxt   = (div_cnt_d == '0) && (bit_cnt_d == '0);
  assign bclk_nxt = (div_cnt_d >= DIV_HALF);
  assign last_cyc = (div_cnt_q == DIV_MAX) && (bit_cnt_q == BIT_MAX);

endmodule

// File: rtl/i2s_stereo_serializer.sv
// Paces the stereo mixer and serialises its left/right results as I2S.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | counters and outputs held at 0, waiting for enable
// ST_RUN   | frames emitted back to back, FS latches data, pulses calcul_en
// ST_DRAIN | enable dropped: finish current frame, then IDLE or back to RUN
module i2s_stereo_serializer import audio_pkg::*; #(
  parameter int DATA_W    = AUDIO_DATA_W,
  parameter int BCLK_DIV  = I2S_BCLK_DIV,
  parameter int SLOT_BITS = I2S_SLOT_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in_right,
  input  logic [DATA_W-1:0] data_in_left,
  output logic              calcul_en,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_sdata,
  output logic              running
);

  localparam int BIT_W = $clog2(2*SLOT_BITS);
  localparam logic [BIT_W-1:0] RIGHT_START = BIT_W'(SLOT_BITS);

  i2s_state_e        state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              calcul_en_q, calcul_en_d;
  logic              bclk_q, bclk_d;
  logic              lrck_q, lrck_d;
  logic              sdata_q, sdata_d;
  logic              running_q, running_d;

  logic [BIT_W-1:0]  bit_nxt;
  logic              fs_nxt, fall_nxt, bclk_nxt, last_cyc;
  logic              active;

  // Counters stay cleared whenever the next state is IDLE; they only
  // advance out of a non-IDLE state, so the first RUN cycle is FS.
  i2s_bit_timer #(
    .BCLK_DIV  (BCLK_DIV),
    .SLOT_BITS (SLOT_BITS),
    .BIT_W     (BIT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_d == ST_IDLE),
    .adv      (state_q != ST_IDLE),
    .bit_nxt  (bit_nxt),
    .fs_nxt   (fs_nxt),
    .fall_nxt (fall_nxt),
    .bclk_nxt (bclk_nxt),
    .last_cyc (last_cyc)
  );

  // Next state: a drop of enable is only acted on at the frame's last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: if (last_cyc) state_d = enable ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign active = (state_d != ST_IDLE);

  // Output and shift logic, computed from the next counter values so the
  // registered outputs line up with the registered counters.
  always_comb begin
    calcul_en_d = active && fs_nxt;
    bclk_d      = active && bclk_nxt;
    lrck_d      = active && (bit_nxt >= RIGHT_START);
    running_d   = active;
    sh_d        = sh_q;
    right_d     = right_q;
    sdata_d     = sdata_q;
    if (!active) begin
      sh_d    = '0;
      right_d = '0;
      sdata_d = 1'b0;
    end else if (fall_nxt) begin
      if (fs_nxt) begin
        // Left goes straight into the shifter; right waits for its slot.
        sh_d    = data_in_left;
        right_d = data_in_right;
        sdata_d = 1'b0;
      end else if (bit_nxt == RIGHT_START) begin
        sh_d    = right_q;
        sdata_d = 1'b0;
      end else begin
        // Zero fill empties the shifter after DATA_W bits, padding the slot.
        sdata_d = sh_q[DATA_W-1];
        sh_d    = {sh_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // State, data and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      right_q     <= '0;
      calcul_en_q <= 1'b0;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      right_q     <= right_d;
      calcul_en_q <= calcul_en_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      running_q   <= running_d;
    end
  end

  assign calcul_en = calcul_en_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;
  assign running   = running_q;

endmodule

// File: tb/tb_i2s_stereo_serializer.sv
// Directed bench for the I2S stereo serializer at default parameters.
module tb_i2s_stereo_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [17:0] data_in_left, data_in_right;
  logic        calcul_en, i2s_bclk, i2s_lrck, i2s_sdata, running;
  logic [4:0]  outs;

  int n_chk  = 0;
  int n_fail = 0;

  // Frame images: 64 sdata bits in wire order, left p0 in bit 63.
  localparam logic [63:0] P_ALT  = {32'h5555_4000, 32'h2AAA_A000}; // L=2AAAA R=15555
  localparam logic [63:0] P_EXT  = {32'h4000_0000, 32'h3FFF_E000}; // L=20000 R=1FFFF
  localparam logic [63:0] P_ONES = {32'h7FFF_E000, 32'h7FFF_E000}; // L=R=3FFFF

  i2s_stereo_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .data_in_right (data_in_right),
    .data_in_left  (data_in_left),
    .calcul_en     (calcul_en),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrck      (i2s_lrck),
    .i2s_sdata     (i2s_sdata),
    .running       (running)
  );

  assign outs = {calcul_en, i2s_bclk, i2s_lrck, i2s_sdata, running};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called while sampling an FS cycle; walks the 1024 cycles of the frame,
  // checking waveform rules and collecting sdata at each BCLK high phase.
  task automatic run_frame(input string tag, input logic [63:0] exp,
                           input int drop_k, input int re_k, input int poke_k,
                           input logic [17:0] pl, input logic [17:0] pr);
    logic [63:0] fr = '0;
    logic        prev_sd = 1'b0;
    int e_bclk = 0, e_lrck = 0, e_sd = 0, e_cal = 0, e_run = 0;
    for (int k = 0; k < 1024; k++) begin
      if (k > 0) tick();
      if (i2s_bclk !== ((k % 16) >= 8)) e_bclk++;
      if (i2s_lrck !== ((k / 16) >= 32)) e_lrck++;
      if ((k % 16) != 0 && i2s_sdata !== prev_sd) e_sd++;
      if (calcul_en !== (k == 0)) e_cal++;
      if (running !== 1'b1) e_run++;
      prev_sd = i2s_sdata;
      if ((k % 16) == 8) fr = {fr[62:0], i2s_sdata};
      if (k == drop_k) enable = 1'b0;
      if (k == re_k) enable = 1'b1;
      if (k == poke_k) begin
        data_in_left  = pl;
        data_in_right = pr;
      end
    end
    check_eq({tag, "_data"}, fr, exp);
    check_eq({tag, "_bclk_err"}, 64'(e_bclk), 64'd0);
    check_eq({tag, "_lrck_err"}, 64'(e_lrck), 64'd0);
    check_eq({tag, "_sdata_hi_err"}, 64'(e_sd), 64'd0);
    check_eq({tag, "_calcul_err"}, 64'(e_cal), 64'd0);
    check_eq({tag, "_running_err"}, 64'(e_run), 64'd0);
  endtask

  initial begin
    int quiet_err;
    rst = 1'b1;
    enable = 1'b0;
    data_in_left  = 18'h2AAAA;
    data_in_right = 18'h15555;
    repeat (3) tick();
    check_eq("reset_outs", 64'(outs), 64'd0);

    // Start: calcul_en in the first cycle after enable is sampled.
    rst = 1'b0;
    enable = 1'b1;
    tick();
    check_eq("first_fs_calcul", 64'(calcul_en), 64'd1);
    check_eq("first_fs_running", 64'(running), 64'd1);
    run_frame("f1_alt", P_ALT, -1, -1, -1, 18'h0, 18'h0);
    tick();
    check_eq("f2_fs_calcul", 64'(calcul_en), 64'd1);
    // Inputs change just after the FS latch: this frame keeps the old words.
    run_frame("f2_alt_midchg", P_ALT, -1, -1, 1, 18'h20000, 18'h1FFFF);
    tick();
    check_eq("f3_fs_calcul", 64'(calcul_en), 64'd1);
    run_frame("f3_ext", P_EXT, -1, -1, 600, 18'h3FFFF, 18'h3FFFF);
    tick();
    run_frame("f4_ones", P_ONES, -1, -1, -1, 18'h0, 18'h0);
    tick();
    // Drop enable at bit_cnt 40: frame completes, then everything idles.
    run_frame("f5_drain", P_ONES, 640, -1, -1, 18'h0, 18'h0);
    tick();
    check_eq("drain_idle_outs", 64'(outs), 64'd0);
    quiet_err = 0;
    repeat (40) begin
      tick();
      if (outs !== 5'd0) quiet_err++;
    end
    check_eq("idle_quiet", 64'(quiet_err), 64'd0);

    // Restart, then drop and re-assert enable inside the same frame.
    data_in_left  = 18'h20000;
    data_in_right = 18'h1FFFF;
    enable = 1'b1;
    tick();
    check_eq("restart_calcul", 64'(calcul_en), 64'd1);
    run_frame("f6_reassert", P_EXT, 100, 200, -1, 18'h0, 18'h0);
    tick();
    check_eq("reassert_fs_calcul", 64'(calcul_en), 64'd1);
    check_eq("reassert_running", 64'(running), 64'd1);

    // Reset at bit_cnt 20 (BCLK high), enable held high throughout.
    data_in_left  = 18'h2AAAA;
    data_in_right = 18'h15555;
    repeat (330) tick();
    check_eq("pre_rst_bclk", 64'(i2s_bclk), 64'd1);
    rst = 1'b1;
    tick();
    check_eq("rst_mid_outs", 64'(outs), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_calcul", 64'(calcul_en), 64'd1);
    run_frame("f7_post_rst", P_ALT, -1, -1, -1, 18'h0, 18'h0);
    tick();
    check_eq("f8_fs_calcul", 64'(calcul_en), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_stereo_serializer.md
Name: i2s_stereo_serializer

Overview:
- Downstream stage of the stereo channel mixer: paces the mixer and consumes its 18-bit left/right results.
- Once per audio frame it pulses calcul_en to start a new mix.
- At the next frame boundary it latches the finished left/right words and serialises them to an external DAC in I2S format (BCLK, LRCK, SDATA).
- Gives one frame of latency from calcul_en to the data appearing on the wire.

Parameters:
- DATA_W, 18: sample width; two's complement; matches mixer output.
- BCLK_DIV, 16: clk cycles per BCLK period; even, >= 4 (50 MHz / 16 = 3.125 MHz BCLK).
- SLOT_BITS, 32: BCLK periods per channel slot; must be >= DATA_W+1. Frame = 2*SLOT_BITS BCLK periods (48.8 kHz at defaults).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run request; sampled every clk
- data_in_right  in  DATA_W  mixer right result
- data_in_left  in  DATA_W  mixer left result
- calcul_en  out  1  one-clk pulse: start mixer computation
- i2s_bclk  out  1  bit clock
- i2s_lrck  out  1  word select: 0 = left, 1 = right
- i2s_sdata  out  1  serial data, MSB first
- running  out  1  high while frames are being emitted

Behaviour:
- All outputs are registered. Reset values: calcul_en=0, i2s_bclk=0, i2s_lrck=0, i2s_sdata=0, running=0, counters=0, shift register=0, state=IDLE.
- Counters:
  - div_cnt runs 0..BCLK_DIV-1.
  - bit_cnt runs 0..2*SLOT_BITS-1 and advances when div_cnt wraps.
- BCLK waveform: i2s_bclk=0 for div_cnt < BCLK_DIV/2, else 1. SDATA and LRCK change only at div_cnt==0 (the BCLK falling edge); the DAC samples on the rising edge.
- Frame start event (FS) is the cycle where div_cnt==0 and bit_cnt==0. On FS:
  - latch data_in_left and data_in_right into the frame shift buffers;
  - pulse calcul_en for exactly 1 clk.
  - The mixer therefore has one full frame (2*SLOT_BITS*BCLK_DIV = 1024 clk) to produce the next pair. The inputs must be stable at FS and are not sampled at any other time.
- LRCK: i2s_lrck = (bit_cnt >= SLOT_BITS).
- I2S one-bit delay. Slot position p = bit_cnt mod SLOT_BITS:
  - p=0 carries 0;
  - p=1..DATA_W carry bits DATA_W-1..0 of the slot's word;
  - p > DATA_W carries 0.
  - Data is sent unmodified (no saturation, no sign extension).
- State machine:
  - IDLE: counters held at 0; bclk, lrck, sdata and running held at 0; no calcul_en. On enable=1 go to RUN. The first RUN cycle is FS, so calcul_en pulses 1 clk after enable is seen.
  - RUN: running=1; counters free-run. If enable=0 is sampled at any time, go to DRAIN.
  - DRAIN: running=1; the current frame completes. At the cycle where div_cnt==BCLK_DIV-1 and bit_cnt==2*SLOT_BITS-1:
    - if enable=1, go to RUN (the next cycle is a normal FS);
    - else go to IDLE with outputs forced to 0. No calcul_en is issued for the aborted next frame.
- Simultaneous events: if enable falls on an FS cycle, that FS still latches and pulses calcul_en; the frame is emitted fully, then the block stops.
- rst mid-frame: all state returns to reset values on the next clk edge regardless of position. The partial frame is truncated and no drain occurs.
- Wrap-around: bit_cnt wraps 2*SLOT_BITS-1 -> 0 only when div_cnt wraps. Both counters wrap with no gap cycles, so the frame period is exact.

Decomposition:
- Shared package `audio_pkg`: AUDIO_DATA_W=18, I2S_SLOT_BITS=32, I2S_BCLK_DIV=16, and the state encoding constants (IDLE, RUN, DRAIN).
- One natural sub-module, `i2s_bit_timer`, holding div_cnt and bit_cnt plus the FS, falling-edge, last-cycle and bclk-level strobes.
- The parent keeps the state machine, latches and shift logic.

Test Plan:
- Reset, then enable=1 with left=18'h2AAAA and right=18'h15555.
  - Required: calcul_en pulses at cycle 1 after enable, then every 1024 clk.
  - Required: the frame after next shows on sdata: left slot 0,1,0,1,… (18 bits from p=1), then 13 zeros; right slot 0,0,1,0,1,… (18 bits), then zeros.
- Timing check at defaults:
  - bclk period 16 clk with 50% duty;
  - lrck toggles every 512 clk, only on bclk falling edges;
  - sdata never changes while bclk=1.
- Extremes: left=18'h20000 and right=18'h1FFFF.
  - Required left: p=1 bit 1, p=2..18 bits 0.
  - Required right: p=1 bit 0, p=2..18 bits 1.
  - Required: bits p=0 and p>=19 are 0 in both slots.
- Change the inputs mid-frame (not at FS): the transmitted words are unchanged until the next FS latch.
- Drop enable at bit_cnt=40:
  - the frame completes through bit_cnt=63;
  - then running=0 and all outputs are 0;
  - no further calcul_en.
  - Re-assert enable in DRAIN: no idle gap, normal FS follows.
- Assert rst at bit_cnt=20: the next clk has all outputs 0 and state IDLE; with enable held high, FS with calcul_en follows 1 clk after rst deasserts.
